memc_dma_responder: RTL and testbench
=====================================

# memc_dma_responder

Memory-controller-side responder for one PE lane's DMA stream-0 port. It is the other end of the `dma__memc__*` / `memc__dma__*` handshake that `dma_cont` initiates. It accepts DMA write and read requests, issues them to a single-ported SRAM bank with fixed read latency, and returns read data through a credit-protected FIFO that honours `read_pause`. It also yields the bank to the SIMD load/store unit on request, after draining all DMA traffic in flight.

## Interface
Parameters:
- ADDR_WIDTH, 24, DMA/SRAM word address width
- DATA_WIDTH, 32, data width
- MEM_LAT, 2, SRAM read latency in cycles (≥1)
- RD_FIFO_DEPTH, 4, read-return FIFO depth (≥ MEM_LAT+1, power of 2)

Ports:
- clk  in  1  system clock; the block uses this single clock
- reset_poweron  in  1  synchronous, active-high reset
- dma__memc__write_valid  in  1  DMA write request
- dma__memc__write_address  in  ADDR_WIDTH  write address
- dma__memc__write_data  in  DATA_WIDTH  write data
- memc__dma__write_ready  out  1  write accepted when valid&ready
- dma__memc__read_valid  in  1  DMA read request
- dma__memc__read_address  in  ADDR_WIDTH  read address
- dma__memc__read_pause  in  1  DMA cannot take return data this cycle
- memc__dma__read_ready  out  1  read accepted when valid&ready
- memc__dma__read_data  out  DATA_WIDTH  return data (FIFO head)
- memc__dma__read_data_valid  out  1  return data transferred this cycle
- ldst__memc__request  in  1  SIMD load/store wants the bank
- ldst__memc__released  in  1  SIMD load/store returns the bank
- memc__ldst__granted  out  1  bank owned by load/store; the external mux selects the ldst path
- memc__sram__enable  out  1  SRAM access strobe
- memc__sram__write  out  1  1=write, 0=read
- memc__sram__address  out  ADDR_WIDTH  SRAM address
- memc__sram__write_data  out  DATA_WIDTH  SRAM write data
- sram__memc__read_data  in  DATA_WIDTH  valid exactly MEM_LAT cycles after a read strobe

## Operation
- State machine has three states: DMA (reset state), DRAIN, LDST.
- **DMA state:**
  - write_ready=1.
  - read_ready = !write_valid && (outstanding < RD_FIFO_DEPTH). Writes have priority and the bank is single-ported.
  - outstanding = reads in the SRAM pipeline plus FIFO occupancy.
- Accepted write: sram enable=1, write=1, address and data passed through combinationally in the same cycle.
- Accepted read: sram enable=1, write=0. A MEM_LAT-deep valid shift register tags the return, and the tagged data is pushed into the FIFO.
- Return path: read_data_valid = !fifo_empty && !read_pause. A pop occurs when read_data_valid=1. read_data = FIFO head, held stable while paused.
- DMA→DRAIN: ldst__memc__request=1 sampled in DMA. Read and write requests accepted in that same cycle still complete.
- **DRAIN state:**
  - Both readies are 0 and no new SRAM strobes are issued.
  - The state waits until outstanding==0 (pipeline empty, FIFO empty, data delivered despite any pause), then moves to LDST.
- **LDST state:**
  - granted=1, memc__sram__enable=0, both readies 0.
  - ldst__memc__released=1 moves the state to DMA on the next cycle.
  - A request that stays high after release is ignored for one cycle, then re-arbitrated.
- Read data ordering is strictly in-order. The FIFO can never overflow because reads are credited at issue.

## Timing
- Reset values: write_ready=0, read_ready=0, read_data_valid=0, read_data=0, granted=0, sram enable/write=0, address/write_data=0. The valid pipeline and FIFO are emptied. State=DMA, and readies rise on the first cycle after reset deasserts.
- Write latency: the SRAM strobe is issued in the acceptance cycle.
- Read latency with no pause: accept at cycle T, SRAM data at T+MEM_LAT, FIFO push at end of T+MEM_LAT, read_data_valid at T+MEM_LAT+1. Back-to-back reads sustain 1/cycle.
- Pause: with pause held, at most RD_FIFO_DEPTH reads are outstanding and read_ready drops. When pause clears, data resumes the same cycle and ready re-rises on the cycle after the first pop.
- Simultaneous push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo RD_FIFO_DEPTH.
- granted asserts the cycle after outstanding reaches 0 in DRAIN and deasserts the cycle after released.
- Reset asserted mid-operation (any state) discards in-flight reads and FIFO contents and returns to DMA with the reset values above.

## Test plan
- **Write then read:** write 0xDEADBEEF to 0x000010, then read 0x000010 with MEM_LAT=2 → read_data_valid one cycle at accept+3 with 0xDEADBEEF.
- **Streaming reads:** 16 consecutive reads of addresses 0..15 (preloaded with value=addr) → 16 valid beats, in order, 1/cycle after a 3-cycle fill.
- **Pause backpressure:** pause held high during 8 issued reads → read_ready falls after exactly 4 accepts. Release pause → 4 beats, ready returns, all 8 values delivered in order with no loss or duplication.
- **Write/read collision:** write_valid and read_valid high in the same cycle → write strobed, read_ready=0. The read is accepted the next cycle.
- **LDST handover:** ldst request with 3 reads outstanding and pause=1 → granted stays 0 until pause drops and 3 beats drain. granted=1 one cycle after the last beat, sram enable=0 throughout LDST. released → readies=1 next cycle.
- **Reset mid-read:** assert reset_poweron with 2 reads in the pipeline → no read_data_valid after reset. All outputs take their reset values, and the FIFO is empty.

Source files
------------

// File: rtl/memc_dma_responder.sv
// memc_dma_responder
//
// Memory-controller responder for one PE lane's DMA stream-0 port. DMA write
// and read requests are issued to a single-ported SRAM bank that has a fixed
// read latency. Read data returns in order through a small FIFO. Reads are
// credited at issue, so the FIFO cannot overflow. On request, the bank is handed
// to the SIMD load/store unit once all DMA traffic in flight has drained.
//
// Handshake semantics (all request channels): a request transfers in the cycle
// where valid and ready are both high. Ready never depends on the address or
// data of the same channel. read_ready does look at write_valid, because
// writes win the single SRAM port. The return channel has no ready. The DMA
// side raises read_pause instead. read_data_valid means "this beat is taken
// now", and the FIFO head stays stable while paused.
//
// Ports
//   clk, reset_poweron           single clock, synchronous active-high reset
//   dma__memc__write_*           write request (valid/address/data)
//   memc__dma__write_ready       write accepted when valid & ready
//   dma__memc__read_valid/_address  read request
//   dma__memc__read_pause        DMA cannot take return data this cycle
//   memc__dma__read_ready        read accepted when valid & ready
//   memc__dma__read_data(_valid) return beat (FIFO head)
//   ldst__memc__request/released load/store arbitration
//   memc__ldst__granted          bank owned by load/store
//   memc__sram__*                SRAM strobe, direction, address, write data
//   sram__memc__read_data        SRAM data, valid MEM_LAT cycles after strobe
//   dbg_state                    current arbitration state (DMA/DRAIN/LDST)

module memc_dma_responder #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LAT       = 2,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dma__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
  input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
  output logic                  memc__dma__write_ready,
  input  logic                  dma__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
  input  logic                  dma__memc__read_pause,
  output logic                  memc__dma__read_ready,
  output logic [DATA_WIDTH-1:0] memc__dma__read_data,
  output logic                  memc__dma__read_data_valid,
  input  logic                  ldst__memc__request,
  input  logic                  ldst__memc__released,
  output logic                  memc__ldst__granted,
  output logic                  memc__sram__enable,
  output logic                  memc__sram__write,
  output logic [ADDR_WIDTH-1:0] memc__sram__address,
  output logic [DATA_WIDTH-1:0] memc__sram__write_data,
  input  logic [DATA_WIDTH-1:0] sram__memc__read_data,
  output logic [1:0]            dbg_state
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_DMA   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LDST  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rearb_hold_q;
  logic [CNT_W-1:0]     outstanding_q;
  logic [MEM_LAT-1:0]   rd_vld_q;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     fifo_cnt_q;

  logic wr_accept, rd_accept, push, pop, fifo_empty, drain_done;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign wr_accept  = dma__memc__write_valid & memc__dma__write_ready;
  assign rd_accept  = dma__memc__read_valid & memc__dma__read_ready;
  // The oldest stage of the valid pipe lines up with SRAM data.
  assign push       = rd_vld_q[MEM_LAT-1];
  assign pop        = memc__dma__read_data_valid;

  // Drain completes when the last outstanding beat leaves this cycle. No new
  // reads can be accepted outside DMA, so only the pop matters here.
  assign drain_done = (outstanding_q == '0) ||
                      ((outstanding_q == CNT_W'(1)) && pop);

  assign dbg_state = state_q;

  // Arbitration state machine: next state and handshake outputs
  always_comb begin
    state_d                = state_q;
    memc__dma__write_ready = 1'b0;
    memc__dma__read_ready  = 1'b0;
    memc__ldst__granted    = 1'b0;
    case (state_q)
      ST_DMA: begin
        memc__dma__write_ready = 1'b1;
        memc__dma__read_ready  = !dma__memc__write_valid &&
                                 (outstanding_q < CNT_W'(RD_FIFO_DEPTH));
        // A request still high right after a release is held off one cycle.
        if (ldst__memc__request && !rearb_hold_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_LDST;
      end
      ST_LDST: begin
        memc__ldst__granted = 1'b1;
        if (ldst__memc__released) state_d = ST_DMA;
      end
      default: state_d = ST_DMA;
    endcase
    // Outputs show their reset values while reset is applied.
    if (reset_poweron) begin
      memc__dma__write_ready = 1'b0;
      memc__dma__read_ready  = 1'b0;
      memc__ldst__granted    = 1'b0;
    end
  end

  // SRAM strobe: writes and reads pass straight through in the accept cycle.
  always_comb begin
    memc__sram__enable     = 1'b0;
    memc__sram__write      = 1'b0;
    memc__sram__address    = '0;
    memc__sram__write_data = '0;
    if (wr_accept) begin
      memc__sram__enable     = 1'b1;
      memc__sram__write      = 1'b1;
      memc__sram__address    = dma__memc__write_address;
      memc__sram__write_data = dma__memc__write_data;
    end else if (rd_accept) begin
      memc__sram__enable     = 1'b1;
      memc__sram__address    = dma__memc__read_address;
    end
  end

  // Return path: head of FIFO, zero when empty so the bus is quiet.
  always_comb begin
    memc__dma__read_data_valid = !reset_poweron && !fifo_empty &&
                                 !dma__memc__read_pause;
    memc__dma__read_data       = '0;
    if (!reset_poweron && !fifo_empty) memc__dma__read_data = fifo_mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q       <= ST_DMA;
      rearb_hold_q  <= 1'b0;
      outstanding_q <= '0;
      rd_vld_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rearb_hold_q  <= (state_q == ST_LDST) && ldst__memc__released;
      // Credits are taken at issue and returned on delivery.
      outstanding_q <= outstanding_q + CNT_W'(rd_accept) - CNT_W'(pop);
      rd_vld_q      <= (rd_vld_q << 1) | MEM_LAT'(rd_accept);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= sram__memc__read_data;
  end

endmodule

// File: tb/tb_memc_dma_responder.sv
// Directed bench for memc_dma_responder (default parameters, MEM_LAT=2,
// RD_FIFO_DEPTH=4). A behavioural SRAM with two-cycle read latency sits
// behind the DUT. Unwritten words read back as their own address.
module tb_memc_dma_responder;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic          write_valid;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_ready;
  logic          read_valid;
  logic [AW-1:0] read_address;
  logic          read_pause;
  logic          read_ready;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic          ldst_request;
  logic          ldst_released;
  logic          granted;
  logic          sram_enable;
  logic          sram_write;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_read_data;
  logic [1:0]    dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int beat_cnt  = 0;
  int b0;
  logic [DW-1:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  memc_dma_responder dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .dma__memc__write_valid     (write_valid),
    .dma__memc__write_address   (write_address),
    .dma__memc__write_data      (write_data),
    .memc__dma__write_ready     (write_ready),
    .dma__memc__read_valid      (read_valid),
    .dma__memc__read_address    (read_address),
    .dma__memc__read_pause      (read_pause),
    .memc__dma__read_ready      (read_ready),
    .memc__dma__read_data       (read_data),
    .memc__dma__read_data_valid (read_data_valid),
    .ldst__memc__request        (ldst_request),
    .ldst__memc__released       (ldst_released),
    .memc__ldst__granted        (granted),
    .memc__sram__enable         (sram_enable),
    .memc__sram__write          (sram_write),
    .memc__sram__address        (sram_address),
    .memc__sram__write_data     (sram_write_data),
    .sram__memc__read_data      (sram_read_data),
    .dbg_state                  (dbg_state)
  );

  // SRAM model: 256 words, two-cycle read latency
  logic [DW-1:0] sram_mem [256];
  logic          sram_init = 1'b0;
  logic [DW-1:0] p0, p1;
  assign sram_read_data = p1;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= DW'(i);
      sram_init <= 1'b1;
    end else if (sram_enable && sram_write) begin
      sram_mem[sram_address[7:0]] <= sram_write_data;
    end
    p0 <= (sram_enable && !sram_write) ? sram_mem[sram_address[7:0]] : '0;
    p1 <= p0;
  end

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every delivered beat must match the oldest expected word
  always @(negedge clk) begin
    if (!reset_poweron && read_data_valid) begin
      beat_cnt++;
      total_cnt++;
      assert (exp_q.size() != 0) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL unexpected_beat: observed data %0h expected no beat", read_data);
      end
      if (exp_q.size() != 0) chk("rd_data", read_data, exp_q.pop_front());
    end
  end

  // driver helpers
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      nxt();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset_poweron = 1'b1;
    write_valid   = 1'b1;   // requests during reset must be ignored
    write_address = 24'h000055;
    write_data    = 32'h55555555;
    read_valid    = 1'b1;
    read_address  = '0;
    read_pause    = 1'b0;
    ldst_request  = 1'b0;
    ldst_released = 1'b0;

    // reset values
    nxt(); nxt(); settle();
    chk("rst_write_ready", write_ready, 0);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_rdv", read_data_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_granted", granted, 0);
    chk("rst_sram_en", sram_enable, 0);
    chk("rst_sram_wr", sram_write, 0);
    chk("rst_sram_addr", sram_address, 0);
    chk("rst_sram_wdata", sram_write_data, 0);

    nxt();
    reset_poweron = 1'b0;
    write_valid   = 1'b0;
    read_valid    = 1'b0;
    settle();
    chk("post_rst_write_ready", write_ready, 1);
    chk("post_rst_read_ready", read_ready, 1);
    chk("post_rst_state", dbg_state, 0);

    // write then read
    nxt();
    write_valid = 1'b1; write_address = 24'h000010; write_data = 32'hDEADBEEF;
    settle();
    chk("wr_ready", write_ready, 1);
    chk("wr_sram_en", sram_enable, 1);
    chk("wr_sram_wr", sram_write, 1);
    chk("wr_sram_addr", sram_address, 24'h000010);
    chk("wr_sram_wdata", sram_write_data, 32'hDEADBEEF);
    chk("wr_read_ready_blocked", read_ready, 0);

    nxt();
    write_valid = 1'b0; read_valid = 1'b1; read_address = 24'h000010;
    settle();
    chk("rd_ready", read_ready, 1);
    chk("rd_sram_en", sram_enable, 1);
    chk("rd_sram_wr", sram_write, 0);
    chk("rd_sram_addr", sram_address, 24'h000010);
    exp_q.push_back(32'hDEADBEEF);
    nxt(); read_valid = 1'b0; settle();
    chk("rd_lat_t1", read_data_valid, 0);
    nxt(); settle();
    chk("rd_lat_t2", read_data_valid, 0);
    nxt(); settle();
    chk("rd_lat_t3", read_data_valid, 1);
    chk("rd_lat_t3_data", read_data, 32'hDEADBEEF);
    nxt(); settle();
    chk("rd_lat_t4", read_data_valid, 0);

    // write/read collision
    nxt();
    write_valid = 1'b1; write_address = 24'h000020; write_data = 32'h12345678;
    read_valid = 1'b1; read_address = 24'h000010;
    settle();
    chk("col_write_ready", write_ready, 1);
    chk("col_read_ready", read_ready, 0);
    chk("col_sram_wr", sram_write, 1);
    chk("col_sram_addr", sram_address, 24'h000020);
    nxt();
    write_valid = 1'b0;
    settle();
    chk("col_read_next", read_ready, 1);
    chk("col_read_sram_wr", sram_write, 0);
    chk("col_read_sram_addr", sram_address, 24'h000010);
    exp_q.push_back(32'hDEADBEEF);
    nxt();
    read_address = 24'h000020;
    settle();
    chk("col_read2_ready", read_ready, 1);
    exp_q.push_back(32'h12345678);
    nxt();
    read_valid = 1'b0;
    drain("col_drain");

    // streaming reads 0..15
    b0 = beat_cnt;
    for (int k = 0; k < 20; k++) begin
      nxt();
      read_valid = (k < 16);
      read_address = AW'(k);
      settle();
      if (k < 16) begin
        chk("stream_ready", read_ready, 1);
        exp_q.push_back(DW'(k));
      end
      if (k == 2) chk("stream_fill_k2", read_data_valid, 0);
      if (k == 3) begin
        chk("stream_first_k3", read_data_valid, 1);
        chk("stream_first_data", read_data, 0);
      end
      if (k == 18) begin
        chk("stream_last_k18", read_data_valid, 1);
        chk("stream_last_data", read_data, 15);
      end
      if (k == 19) begin
        chk("stream_end_k19", read_data_valid, 0);
        chk("stream_beats", beat_cnt - b0, 16);
      end
    end

    // pause backpressure
    read_pause = 1'b1;
    b0 = beat_cnt;
    for (int k = 0; k < 8; k++) begin
      nxt();
      read_valid = 1'b1;
      read_address = (k < 4) ? AW'(k) : 24'd4;
      settle();
      chk("pause_ready", read_ready, (k < 4) ? 1 : 0);
      chk("pause_no_rdv", read_data_valid, 0);
      if (k < 4) exp_q.push_back(DW'(k));
    end
    nxt();
    read_pause = 1'b0;
    read_address = 24'd4;
    settle();
    chk("unpause_ready_low", read_ready, 0);
    chk("unpause_rdv", read_data_valid, 1);
    chk("unpause_data", read_data, 0);
    for (int j = 0; j < 4; j++) begin
      nxt();
      read_address = AW'(4 + j);
      settle();
      chk("unpause_ready", read_ready, 1);
      exp_q.push_back(DW'(4 + j));
    end
    nxt();
    read_valid = 1'b0;
    repeat (3) nxt();
    settle();
    chk("pause_beats", beat_cnt - b0, 8);
    chk("pause_q_empty", exp_q.size(), 0);

    // LDST handover with three reads held by pause
    read_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      read_valid = 1'b1;
      read_address = AW'(5 + i);
      settle();
      chk("ho_ready", read_ready, 1);
      exp_q.push_back(DW'(5 + i));
    end
    nxt();
    read_valid = 1'b0;
    ldst_request = 1'b1;
    settle();
    chk("ho_req_granted", granted, 0);
    chk("ho_req_state", dbg_state, 0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      read_valid = 1'b1;
      read_address = 24'd9;
      settle();
      chk("drain_read_ready", read_ready, 0);
      chk("drain_write_ready", write_ready, 0);
      chk("drain_sram_en", sram_enable, 0);
      chk("drain_granted", granted, 0);
      chk("drain_state", dbg_state, 1);
    end
    nxt();
    read_valid = 1'b0;
    read_pause = 1'b0;
    settle();
    chk("ho_beat0", read_data_valid, 1);
    chk("ho_beat0_data", read_data, 5);
    chk("ho_beat0_granted", granted, 0);
    nxt(); settle();
    chk("ho_beat1_granted", granted, 0);
    nxt(); settle();
    chk("ho_beat2", read_data_valid, 1);
    chk("ho_beat2_granted", granted, 0);
    nxt(); settle();
    chk("ho_granted", granted, 1);
    chk("ho_granted_rdv", read_data_valid, 0);
    chk("ho_q_empty", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      write_valid = 1'b1; write_address = 24'h000030; write_data = 32'hCAFEF00D;
      read_valid = 1'b1;
      settle();
      chk("ldst_sram_en", sram_enable, 0);
      chk("ldst_write_ready", write_ready, 0);
      chk("ldst_read_ready", read_ready, 0);
      chk("ldst_granted", granted, 1);
    end
    nxt();
    write_valid = 1'b0; read_valid = 1'b0;
    ldst_released = 1'b1;   // request stays high
    settle();
    chk("rel_granted", granted, 1);
    nxt();
    ldst_released = 1'b0;
    settle();
    chk("rel_next_granted", granted, 0);
    chk("rel_next_write_ready", write_ready, 1);
    chk("rel_next_read_ready", read_ready, 1);
    chk("rel_next_state", dbg_state, 0);
    nxt(); settle();
    chk("rearb_hold_state", dbg_state, 0);
    nxt(); settle();
    chk("rearb_drain_state", dbg_state, 1);
    chk("rearb_drain_write_ready", write_ready, 0);
    nxt(); settle();
    chk("rearb_granted", granted, 1);
    nxt();
    ldst_released = 1'b1;
    ldst_request = 1'b0;
    nxt();
    ldst_released = 1'b0;
    settle();
    chk("rearb_back_ready", write_ready, 1);
    chk("rearb_back_granted", granted, 0);

    // reset mid-read
    nxt();
    read_valid = 1'b1; read_address = 24'd1;
    settle();
    chk("mr_ready0", read_ready, 1);
    nxt();
    read_address = 24'd2;
    settle();
    chk("mr_ready1", read_ready, 1);
    nxt();
    read_valid = 1'b0;
    reset_poweron = 1'b1;
    settle();
    chk("mr_rst_read_ready", read_ready, 0);
    chk("mr_rst_write_ready", write_ready, 0);
    chk("mr_rst_rdv", read_data_valid, 0);
    chk("mr_rst_sram_en", sram_enable, 0);
    chk("mr_rst_granted", granted, 0);
    exp_q.delete();   // both in-flight reads are discarded
    nxt();
    reset_poweron = 1'b0;
    settle();
    chk("mr_post_read_ready", read_ready, 1);
    chk("mr_post_rdv", read_data_valid, 0);
    chk("mr_post_read_data", read_data, 0);
    b0 = beat_cnt;
    for (int k = 0; k < 4; k++) begin
      nxt(); settle();
      chk("mr_quiet_rdv", read_data_valid, 0);
    end
    chk("mr_no_beats", beat_cnt - b0, 0);
    nxt();
    read_valid = 1'b1; read_address = 24'd3;
    settle();
    chk("mr_after_ready", read_ready, 1);
    exp_q.push_back(32'd3);
    nxt();
    read_valid = 1'b0;
    drain("mr_after_drain");

    nxt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
